// File: rtl/scpad_write_assembler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// scpad_write_assembler: collects interleaved DRAM beats into SRAM rows.
// Rev 1.0
// ============================================================================
module scpad_write_assembler #(
  parameter int BEAT_W    = 64,
  parameter int ROW_W     = 512,
  parameter int NUM_SLOTS = 4,
  parameter int ID_W      = 8,
  parameter int XBAR_W    = 32
) (
  input  logic                                 CLK,
  input  logic                                 nRST,
  input  logic                                 alloc_valid,
  output logic                                 alloc_ready,
  input  logic [ID_W-1:0]                      alloc_id,
  input  logic [$clog2(ROW_W/BEAT_W)-1:0]      alloc_num_beats,
  input  logic [XBAR_W-1:0]                    alloc_xbar,
  input  logic                                 beat_valid,
  input  logic [ID_W-1:0]                      beat_id,
  input  logic [BEAT_W-1:0]                    beat_data,
  output logic                                 req_valid,
  input  logic                                 req_ready,
  output logic [ROW_W-1:0]                     req_wdata,
  output logic [XBAR_W-1:0]                    req_xbar,
  output logic [ID_W-1:0]                      req_id,
  output logic                                 err_valid,
  output logic [ID_W-1:0]                      err_id,
  output logic [$clog2(NUM_SLOTS):0]           slots_busy
);

  localparam int MAX_BEATS = ROW_W / BEAT_W;
  localparam int CNT_W     = $clog2(MAX_BEATS);
  localparam int SLOT_W    = $clog2(NUM_SLOTS);
  localparam int BUSY_W    = SLOT_W + 1;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_FILLING = 2'd1,
    SLOT_FULL    = 2'd2
  } slot_state_e;

  slot_state_e        state_q [NUM_SLOTS];
  slot_state_e        state_d [NUM_SLOTS];
  logic [ID_W-1:0]    id_q    [NUM_SLOTS];
  logic [ID_W-1:0]    id_d    [NUM_SLOTS];
  logic [XBAR_W-1:0]  xbar_q  [NUM_SLOTS];
  logic [XBAR_W-1:0]  xbar_d  [NUM_SLOTS];
  logic [CNT_W-1:0]   exp_q   [NUM_SLOTS];
  logic [CNT_W-1:0]   exp_d   [NUM_SLOTS];
  logic [CNT_W-1:0]   cnt_q   [NUM_SLOTS];
  logic [CNT_W-1:0]   cnt_d   [NUM_SLOTS];
  logic [ROW_W-1:0]   data_q  [NUM_SLOTS];
  logic [ROW_W-1:0]   data_d  [NUM_SLOTS];

  logic [SLOT_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SLOT_W-1:0]  sel_q, sel_d;
  logic               lock_q, lock_d;
  logic               err_valid_q, err_valid_d;
  logic [ID_W-1:0]    err_id_q, err_id_d;
  logic [BUSY_W-1:0]  busy_q, busy_d;

  logic               any_free;
  logic               dup_id;
  logic [SLOT_W-1:0]  alloc_slot;
  logic               hit;
  logic [SLOT_W-1:0]  hit_slot;
  logic               any_full;
  logic [SLOT_W-1:0]  rr_sel;
  logic [SLOT_W-1:0]  rr_idx;
  logic               rr_found;
  logic [SLOT_W-1:0]  sel;
  logic [CNT_W:0]     exp_full;
  logic               alloc_fire;
  logic               req_fire;

  // Slot lookup: free slot, duplicate ID, beat hit and round-robin candidate.
  always_comb begin
    any_free   = 1'b0;
    alloc_slot = '0;
    dup_id     = 1'b0;
    hit        = 1'b0;
    hit_slot   = '0;
    any_full   = 1'b0;
    rr_found   = 1'b0;
    rr_sel     = rr_ptr_q;
    rr_idx     = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (state_q[i] == SLOT_FREE) begin
        any_free   = 1'b1;
        alloc_slot = SLOT_W'(i);
      end else if (id_q[i] == alloc_id) begin
        dup_id = 1'b1;
      end
      if (state_q[i] == SLOT_FILLING && id_q[i] == beat_id) begin
        hit      = 1'b1;
        hit_slot = SLOT_W'(i);
      end
      if (state_q[i] == SLOT_FULL) begin
        any_full = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      rr_idx = rr_ptr_q + SLOT_W'(i);
      if (!rr_found && state_q[rr_idx] == SLOT_FULL) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
    end
  end

  // A stalled request keeps its grant so the outputs hold until accepted.
  assign sel         = lock_q ? sel_q : rr_sel;
  assign alloc_ready = any_free & ~dup_id;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign req_valid   = any_full;
  assign req_fire    = req_valid & req_ready;
  assign req_wdata   = req_valid ? data_q[sel] : '0;
  assign req_xbar    = req_valid ? xbar_q[sel] : '0;
  assign req_id      = req_valid ? id_q[sel]   : '0;
  assign err_valid   = err_valid_q;
  assign err_id      = err_id_q;
  assign slots_busy  = busy_q;

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    xbar_d      = xbar_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel;
    lock_d      = req_valid & ~req_ready;
    err_valid_d = beat_valid & ~hit;
    err_id_d    = (beat_valid & ~hit) ? beat_id : '0;
    busy_d      = '0;
    exp_full    = (exp_q[hit_slot] == '0) ? (CNT_W+1)'(MAX_BEATS)
                                          : {1'b0, exp_q[hit_slot]};

    if (alloc_fire) begin
      state_d[alloc_slot] = SLOT_FILLING;
      id_d[alloc_slot]    = alloc_id;
      xbar_d[alloc_slot]  = alloc_xbar;
      exp_d[alloc_slot]   = alloc_num_beats;
      cnt_d[alloc_slot]   = '0;
      data_d[alloc_slot]  = '0;
    end

    if (beat_valid && hit) begin
      data_d[hit_slot][int'(cnt_q[hit_slot]) * BEAT_W +: BEAT_W] = beat_data;
      cnt_d[hit_slot] = cnt_q[hit_slot] + CNT_W'(1);
      if ({1'b0, cnt_q[hit_slot]} + (CNT_W+1)'(1) == exp_full) begin
        state_d[hit_slot] = SLOT_FULL;
      end
    end

    if (req_fire) begin
      state_d[sel] = SLOT_FREE;
      rr_ptr_d     = sel + SLOT_W'(1);
    end

    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (state_d[i] != SLOT_FREE) begin
        busy_d = busy_d + BUSY_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= SLOT_FREE;
        id_q[i]    <= '0;
        xbar_q[i]  <= '0;
        exp_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      lock_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_id_q    <= '0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      xbar_q      <= xbar_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      lock_q      <= lock_d;
      err_valid_q <= err_valid_d;
      err_id_q    <= err_id_d;
      busy_q      <= busy_d;
    end
  end

  // Row storage needs no reset; allocation clears it.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      data_q <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scpad_write_assembler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_scpad_write_assembler: directed self-checking bench.
// Rev 1.0
// ============================================================================
module tb_scpad_write_assembler;
  localparam int RW = 512;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          alloc_valid;
  logic          alloc_ready;
  logic [7:0]    alloc_id;
  logic [2:0]    alloc_num_beats;
  logic [31:0]   alloc_xbar;
  logic          beat_valid;
  logic [7:0]    beat_id;
  logic [63:0]   beat_data;
  logic          req_valid;
  logic          req_ready;
  logic [RW-1:0] req_wdata;
  logic [31:0]   req_xbar;
  logic [7:0]    req_id;
  logic          err_valid;
  logic [7:0]    err_id;
  logic [2:0]    slots_busy;

  int checks = 0;
  int errors = 0;

  scpad_write_assembler #(
    .BEAT_W(64), .ROW_W(RW), .NUM_SLOTS(4), .ID_W(8), .XBAR_W(32)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .alloc_num_beats(alloc_num_beats), .alloc_xbar(alloc_xbar),
    .beat_valid(beat_valid), .beat_id(beat_id), .beat_data(beat_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_wdata(req_wdata),
    .req_xbar(req_xbar), .req_id(req_id),
    .err_valid(err_valid), .err_id(err_id), .slots_busy(slots_busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic alloc(input logic [7:0] id, input logic [2:0] nb, input logic [31:0] xb);
    alloc_valid = 1'b1; alloc_id = id; alloc_num_beats = nb; alloc_xbar = xb;
    #1 check("alloc_ready", RW'(alloc_ready), RW'(1'b1));
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic beat(input logic [7:0] id, input logic [63:0] d);
    beat_valid = 1'b1; beat_id = id; beat_data = d;
    tick();
    beat_valid = 1'b0;
  endtask

  function automatic logic [RW-1:0] row_of(input int id);
    logic [RW-1:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) r[b*64 +: 64] = 64'(id * 256 + b);
    return r;
  endfunction

  logic [RW-1:0] exp_row;
  int            exp_ids [3];

  initial begin
    nRST = 1'b0; alloc_valid = 1'b0; alloc_id = '0; alloc_num_beats = '0; alloc_xbar = '0;
    beat_valid = 1'b0; beat_id = '0; beat_data = '0; req_ready = 1'b0;
    tick(); tick();
    check("rst_req_valid", RW'(req_valid), RW'(1'b0));
    check("rst_busy", RW'(slots_busy), RW'(3'd0));
    check("rst_alloc_ready", RW'(alloc_ready), RW'(1'b1));
    check("rst_err_valid", RW'(err_valid), RW'(1'b0));
    nRST = 1'b1;
    tick();

    // Full-length row with default beat count
    alloc(8'h12, 3'd0, 32'hDEADBEEF);
    exp_row = '0;
    for (int k = 0; k < 8; k++) begin
      beat_valid = 1'b1; beat_id = 8'h12; beat_data = 64'(k);
      exp_row[k*64 +: 64] = 64'(k);
      if (k == 7) check("t1_not_yet", RW'(req_valid), RW'(1'b0));
      tick();
    end
    beat_valid = 1'b0;
    check("t1_req_valid", RW'(req_valid), RW'(1'b1));
    check("t1_req_id", RW'(req_id), RW'(8'h12));
    check("t1_req_xbar", RW'(req_xbar), RW'(32'hDEADBEEF));
    check("t1_wdata", req_wdata, exp_row);
    check("t1_busy", RW'(slots_busy), RW'(3'd1));
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    check("t1_drained", RW'(req_valid), RW'(1'b0));
    check("t1_busy0", RW'(slots_busy), RW'(3'd0));

    // Short row: upper bits must stay zero
    alloc(8'h20, 3'd3, 32'h1);
    beat(8'h20, 64'hAAAA_0000_0000_000A);
    beat(8'h20, 64'hBBBB_0000_0000_000B);
    beat(8'h20, 64'hCCCC_0000_0000_000C);
    exp_row = '0;
    exp_row[191:0] = {64'hCCCC_0000_0000_000C, 64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    check("t2_req_valid", RW'(req_valid), RW'(1'b1));
    check("t2_wdata", req_wdata, exp_row);
    req_ready = 1'b1; tick(); req_ready = 1'b0;

    // Unallocated ID is dropped
    beat(8'h55, 64'h1);
    check("e1_err_valid", RW'(err_valid), RW'(1'b1));
    check("e1_err_id", RW'(err_id), RW'(8'h55));
    check("e1_busy", RW'(slots_busy), RW'(3'd0));
    tick();
    check("e1_err_clear", RW'(err_valid), RW'(1'b0));

    // Alloc and beat with the same ID in one cycle: beat misses
    alloc_valid = 1'b1; alloc_id = 8'h07; alloc_num_beats = 3'd1; alloc_xbar = 32'h7;
    beat_valid = 1'b1; beat_id = 8'h07; beat_data = 64'h70;
    tick();
    alloc_valid = 1'b0; beat_valid = 1'b0;
    check("e2_err_valid", RW'(err_valid), RW'(1'b1));
    check("e2_err_id", RW'(err_id), RW'(8'h07));
    check("e2_busy", RW'(slots_busy), RW'(3'd1));
    beat(8'h07, 64'h77);
    check("e2_err_clear", RW'(err_valid), RW'(1'b0));
    check("e2_wdata", req_wdata, RW'(64'h77));
    alloc_valid = 1'b1; alloc_id = 8'h07;
    #1 check("e3_dup_ready", RW'(alloc_ready), RW'(1'b0));
    alloc_valid = 1'b0;
    req_ready = 1'b1; tick(); req_ready = 1'b0;

    // Reset so arbitration restarts from slot 0
    nRST = 1'b0; tick(); nRST = 1'b1;
    check("r0_alloc_ready", RW'(alloc_ready), RW'(1'b1));

    // Four interleaved rows
    for (int i = 1; i <= 4; i++) alloc(8'(i), 3'd0, 32'(100 + i));
    alloc_valid = 1'b1; alloc_id = 8'h05; alloc_num_beats = 3'd1; alloc_xbar = 32'h5;
    #1 check("i_full_ready", RW'(alloc_ready), RW'(1'b0));
    check("i_busy4", RW'(slots_busy), RW'(3'd4));
    alloc_valid = 1'b0;
    for (int b = 0; b < 8; b++)
      for (int i = 1; i <= 4; i++) beat(8'(i), 64'(i * 256 + b));
    check("i_req_valid", RW'(req_valid), RW'(1'b1));

    // Backpressure: selection and alloc stall hold
    alloc_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_id", RW'(req_id), RW'(8'd1));
      check("bp_wdata", req_wdata, row_of(1));
      check("bp_alloc_ready", RW'(alloc_ready), RW'(1'b0));
      tick();
    end
    req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("rr_id", RW'(req_id), RW'(8'(k + 1)));
      check("rr_wdata", req_wdata, row_of(k + 1));
      check("rr_xbar", RW'(req_xbar), RW'(32'(101 + k)));
      if (k == 0) check("stall_ready0", RW'(alloc_ready), RW'(1'b0));
      if (k == 1) check("stall_ready1", RW'(alloc_ready), RW'(1'b1));
      tick();
      if (k == 1) alloc_valid = 1'b0;
    end
    req_ready = 1'b0;
    check("rr_done_valid", RW'(req_valid), RW'(1'b0));
    check("rr_done_busy", RW'(slots_busy), RW'(3'd1));

    // Lock then round-robin continuation: slot1 granted, then 2, then 0
    alloc(8'h06, 3'd1, 32'h6);
    alloc(8'h09, 3'd1, 32'h9);
    beat(8'h06, 64'h66);
    check("lk_id_a", RW'(req_id), RW'(8'h06));
    beat(8'h05, 64'h55);
    check("lk_id_b", RW'(req_id), RW'(8'h06));
    beat(8'h09, 64'h99);
    check("lk_id_c", RW'(req_id), RW'(8'h06));
    exp_ids[0] = 6; exp_ids[1] = 9; exp_ids[2] = 5;
    req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("rr2_id", RW'(req_id), RW'(8'(exp_ids[k])));
      check("rr2_wdata", req_wdata, RW'(64'(exp_ids[k] * 17)));
      tick();
    end
    req_ready = 1'b0;
    check("rr2_done", RW'(req_valid), RW'(1'b0));

    // Reset mid-operation
    alloc(8'h30, 3'd0, 32'h30);
    alloc(8'h31, 3'd0, 32'h31);
    alloc(8'h32, 3'd1, 32'h32);
    beat(8'h30, 64'h1);
    beat(8'h31, 64'h2);
    beat(8'h32, 64'h3);
    check("mr_busy", RW'(slots_busy), RW'(3'd3));
    check("mr_valid", RW'(req_valid), RW'(1'b1));
    nRST = 1'b0; tick(); nRST = 1'b1;
    check("mr_rst_valid", RW'(req_valid), RW'(1'b0));
    check("mr_rst_busy", RW'(slots_busy), RW'(3'd0));
    check("mr_rst_ready", RW'(alloc_ready), RW'(1'b1));
    beat(8'h30, 64'h4);
    check("mr_old_err", RW'(err_valid), RW'(1'b1));
    check("mr_old_err_id", RW'(err_id), RW'(8'h30));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
